// File: rtl/onehot_decoder_seq.sv
// Registered 2-to-4 (parameterisable) decoder with a valid/ready intake.
// Each accepted code is driven one-hot for a fixed hold window, followed by a fixed idle gap.
module onehot_decoder_seq #(
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IDX_W-1:0]       in_idx,
    input  logic                   in_none,
    output logic [(1<<IDX_W)-1:0]  y,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned OUT_W   = 1 << IDX_W;
    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    // Only loaded when a gap window exists, so the zero-gap case never underflows.
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Ready is withheld during reset so reset always wins over an accept.
    assign in_ready = (state_q == IDLE) && rst_n;

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next-state, counter and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = DRIVE;
                    cnt_d   = HOLD_LOAD;
                    y_d     = in_none ? '0 : (OUT_W'(1) << in_idx);
                    busy_d  = 1'b1;
                    done_d  = (HOLD_LOAD == '0);
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    y_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    done_d = (cnt_q == CNT_W'(1));
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                y_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench for onehot_decoder_seq: default instance (hold 4, gap 1) and a hold 1 / gap 0 instance.
module tb_onehot_decoder_seq;

    typedef struct packed {
        logic [3:0] y;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_a, ready_a, none_a, busy_a, done_a;
    logic [1:0] idx_a;
    logic [3:0] y_a;
    logic       valid_b, ready_b, none_b, busy_b, done_b;
    logic [1:0] idx_b;
    logic [3:0] y_b;

    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    int   last_accept = 0;
    exp_t q[$];

    onehot_decoder_seq #(.IDX_W(2), .HOLD_CYCLES(4), .GAP_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_a), .in_ready(ready_a),
        .in_idx(idx_a), .in_none(none_a), .y(y_a), .busy(busy_a), .done(done_a)
    );

    onehot_decoder_seq #(.IDX_W(2), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_b), .in_ready(ready_b),
        .in_idx(idx_b), .in_none(none_b), .y(y_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t obs(input bit sel);
        exp_t o;
        if (sel) o = {y_b, busy_b, done_b, ready_b};
        else     o = {y_a, busy_a, done_a, ready_a};
        return o;
    endfunction

    // Expected per-cycle outputs for one accepted code, from the accept edge to the following idle cycle.
    task automatic push_code(input logic [1:0] idx, input bit none, input int hold, input int gap);
        exp_t e;
        logic [3:0] one;
        one = 4'b0001;
        for (int i = 1; i <= hold; i++) begin
            e.y     = none ? 4'b0000 : (one << idx);
            e.busy  = 1'b1;
            e.done  = (i == hold);
            e.ready = 1'b0;
            q.push_back(e);
        end
        for (int i = 0; i < gap; i++) begin
            e = '{y: 4'b0000, busy: 1'b1, done: 1'b0, ready: 1'b0};
            q.push_back(e);
        end
        e = '{y: 4'b0000, busy: 1'b0, done: 1'b0, ready: 1'b1};
        q.push_back(e);
    endtask

    // Offer a code, wait (bounded) for acceptance, then compare each cycle against the scoreboard.
    task automatic send(input bit sel, input logic [1:0] idx, input bit none,
                        input int hold, input int gap, input bit keep, input string name);
        int   n;
        exp_t e;
        exp_t o;
        if (sel) begin valid_b = 1'b1; idx_b = idx; none_b = none; end
        else     begin valid_a = 1'b1; idx_a = idx; none_a = none; end
        n = 0;
        while (obs(sel).ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            checks++;
            $display("FAIL %s accept_timeout: in_ready never rose within 20 cycles", name);
            if (sel) valid_b = 1'b0; else valid_a = 1'b0;
            return;
        end
        last_accept = cyc;
        push_code(idx, none, hold, gap);
        tick();
        if (!keep) begin
            if (sel) valid_b = 1'b0; else valid_a = 1'b0;
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(sel);
            checks++;
            if (o !== e)
                $display("FAIL %s cyc=%0d: got y=%b busy=%b done=%b rdy=%b, expected y=%b busy=%b done=%b rdy=%b",
                         name, cyc, o.y, o.busy, o.done, o.ready, e.y, e.busy, e.done, e.ready);
            else
                passed++;
            if (q.size() > 0) tick();
        end
    endtask

    task automatic check_now(input bit sel, input exp_t e, input string name);
        exp_t o;
        o = obs(sel);
        checks++;
        if (o !== e)
            $display("FAIL %s: got y=%b busy=%b done=%b rdy=%b, expected y=%b busy=%b done=%b rdy=%b",
                     name, o.y, o.busy, o.done, o.ready, e.y, e.busy, e.done, e.ready);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_now(1'b0, '{4'b0000, 1'b0, 1'b0, 1'b0}, "reset_a");
        check_now(1'b1, '{4'b0000, 1'b0, 1'b0, 1'b0}, "reset_b");
        rst_n = 1'b1;
        #1;
        check_now(1'b0, '{4'b0000, 1'b0, 1'b0, 1'b1}, "release_a");
        check_now(1'b1, '{4'b0000, 1'b0, 1'b0, 1'b1}, "release_b");
    endtask

    task automatic test_single();
        send(1'b0, 2'd2, 1'b0, 4, 1, 1'b0, "single_idx2");
    endtask

    task automatic test_none();
        send(1'b0, 2'd0, 1'b1, 4, 1, 1'b0, "none_flag");
    endtask

    task automatic test_back_to_back();
        int prev;
        send(1'b0, 2'd0, 1'b0, 4, 1, 1'b1, "b2b_idx0");
        prev = last_accept;
        send(1'b0, 2'd1, 1'b0, 4, 1, 1'b1, "b2b_idx1");
        checks++;
        if (last_accept - prev !== 6)
            $display("FAIL b2b_spacing1: got %0d cycles, expected 6", last_accept - prev);
        else passed++;
        prev = last_accept;
        send(1'b0, 2'd3, 1'b0, 4, 1, 1'b0, "b2b_idx3");
        checks++;
        if (last_accept - prev !== 6)
            $display("FAIL b2b_spacing2: got %0d cycles, expected 6", last_accept - prev);
        else passed++;
    endtask

    task automatic test_reset_mid();
        valid_a = 1'b1; idx_a = 2'd3; none_a = 1'b0;
        tick();
        valid_a = 1'b0;
        check_now(1'b0, '{4'b1000, 1'b1, 1'b0, 1'b0}, "mid_drive1");
        tick();
        check_now(1'b0, '{4'b1000, 1'b1, 1'b0, 1'b0}, "mid_drive2");
        rst_n = 1'b0;
        #1;
        check_now(1'b0, '{4'b1000, 1'b1, 1'b0, 1'b0}, "mid_rst_ready_low");
        tick();
        check_now(1'b0, '{4'b0000, 1'b0, 1'b0, 1'b0}, "mid_rst_cleared");
        tick();
        check_now(1'b0, '{4'b0000, 1'b0, 1'b0, 1'b0}, "mid_rst_no_done");
        rst_n = 1'b1;
        #1;
        check_now(1'b0, '{4'b0000, 1'b0, 1'b0, 1'b1}, "mid_rst_release");
        send(1'b0, 2'd1, 1'b0, 4, 1, 1'b0, "after_rst_idx1");
    endtask

    task automatic test_zero_gap();
        send(1'b1, 2'd1, 1'b0, 1, 0, 1'b1, "gap0_idx1");
        send(1'b1, 2'd2, 1'b0, 1, 0, 1'b0, "gap0_idx2");
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_a = 1'b0; idx_a = 2'd0; none_a = 1'b0;
        valid_b = 1'b0; idx_b = 2'd0; none_b = 1'b0;
        test_reset();
        test_single();
        test_none();
        test_back_to_back();
        test_reset_mid();
        test_zero_gap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
